// File: rtl/tomasula_types.sv
// rtl/tomasula_types.sv - shared trace record types and constants
// Trace record layout and the halt idiom used by the commit observation path.
package tomasula_types;

  localparam logic [31:0] HALT_INSTR  = 32'h0000006f;
  localparam int          TRACE_SEQ_W = 16;

  typedef struct packed {
    logic [TRACE_SEQ_W-1:0] seq;
    logic [31:0]            pc;
    logic [31:0]            instr;
    logic [4:0]             rd;
    logic [31:0]            rd_wdata;
  } trace_entry_t;

  // x0 writes are architecturally discarded, so the trace reports them as zero.
  function automatic logic [31:0] mask_rd_wdata(input logic [4:0] rd, input logic [31:0] wdata);
    return (rd == 5'd0) ? 32'd0 : wdata;
  endfunction

endpackage

// File: rtl/commit_trace_monitor_fifo.sv
// rtl/commit_trace_monitor_fifo.sv - generic in-order synchronous FIFO of trace records
// Head entry is read combinationally; pointers wrap naturally over a power-of-two depth.
module trace_fifo
  import tomasula_types::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = trace_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Guards keep the FIFO self-consistent even if a caller ignores full/empty.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (wr_en) tail_ptr <= tail_ptr + 1'b1;
      if (rd_en) head_ptr <= head_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[tail_ptr] <= push_data;
  end

  assign head = mem[head_ptr];

endmodule

// File: rtl/commit_trace_monitor.sv
// rtl/commit_trace_monitor.sv - captures committed instructions into a drained trace FIFO
// Owns sequence numbering, drop/overflow accounting, halt detection and push/pop gating.
module commit_trace_monitor
  import tomasula_types::*;
#(
  parameter int  DEPTH  = 8,
  parameter int  SEQ_W  = 16,
  parameter int  DROP_W = 8,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              commit_valid,
  input  logic [31:0]       commit_pc,
  input  logic [31:0]       commit_instr,
  input  logic [4:0]        commit_rd,
  input  logic [31:0]       commit_rd_wdata,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [SEQ_W-1:0]  trace_seq,
  output logic [31:0]       trace_pc,
  output logic [31:0]       trace_instr,
  output logic [4:0]        trace_rd,
  output logic [31:0]       trace_rd_wdata,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  output logic              halt
);

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [4:0]       rd;
    logic [31:0]      rd_wdata;
  } entry_t;

  logic [SEQ_W-1:0] seq_q;
  entry_t           commit_entry;
  entry_t           head_entry;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;

  assign trace_valid = !empty;
  assign pop         = trace_valid && trace_ready;
  // A full FIFO still accepts a commit when the head leaves in the same cycle.
  assign push        = commit_valid && (!full || pop);
  assign drop        = commit_valid && full && !pop;

  always_comb begin
    commit_entry          = '0;
    commit_entry.seq      = seq_q;
    commit_entry.pc       = commit_pc;
    commit_entry.instr    = commit_instr;
    commit_entry.rd       = commit_rd;
    commit_entry.rd_wdata = mask_rd_wdata(commit_rd, commit_rd_wdata);
  end

  trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (commit_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  // Sequence advances on dropped commits too, so the consumer can see gaps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_q      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      halt       <= 1'b0;
    end else begin
      if (commit_valid) seq_q <= seq_q + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
      if (commit_valid && commit_instr == HALT_INSTR) halt <= 1'b1;
    end
  end

  // Stale storage is hidden behind trace_valid so an empty FIFO reads all zeros.
  assign trace_seq      = trace_valid ? head_entry.seq      : '0;
  assign trace_pc       = trace_valid ? head_entry.pc       : '0;
  assign trace_instr    = trace_valid ? head_entry.instr    : '0;
  assign trace_rd       = trace_valid ? head_entry.rd       : '0;
  assign trace_rd_wdata = trace_valid ? head_entry.rd_wdata : '0;

endmodule

// File: tb/tb_commit_trace_monitor.sv
// tb/tb_commit_trace_monitor.sv - self-checking bench for commit_trace_monitor
// Table-driven ordering vectors plus scripted fill/drop/halt/reset sequences against a queue model.
module tb_commit_trace_monitor;

  localparam int DEPTH  = 8;
  localparam int SEQ_W  = 16;
  localparam int DROP_W = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              commit_valid = 1'b0;
  logic [31:0]       commit_pc = '0;
  logic [31:0]       commit_instr = '0;
  logic [4:0]        commit_rd = '0;
  logic [31:0]       commit_rd_wdata = '0;
  logic              trace_valid;
  logic              trace_ready = 1'b0;
  logic [SEQ_W-1:0]  trace_seq;
  logic [31:0]       trace_pc;
  logic [31:0]       trace_instr;
  logic [4:0]        trace_rd;
  logic [31:0]       trace_rd_wdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;
  logic              halt;

  commit_trace_monitor #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .DROP_W(DROP_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .commit_valid    (commit_valid),
    .commit_pc       (commit_pc),
    .commit_instr    (commit_instr),
    .commit_rd       (commit_rd),
    .commit_rd_wdata (commit_rd_wdata),
    .trace_valid     (trace_valid),
    .trace_ready     (trace_ready),
    .trace_seq       (trace_seq),
    .trace_pc        (trace_pc),
    .trace_instr     (trace_instr),
    .trace_rd        (trace_rd),
    .trace_rd_wdata  (trace_rd_wdata),
    .fifo_count      (fifo_count),
    .overflow        (overflow),
    .drop_count      (drop_count),
    .halt            (halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } rec_t;

  typedef struct {
    logic        cv;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        rdy;
    logic        e_valid;
    logic [15:0] e_seq;
    logic [31:0] e_pc;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic [3:0]  e_cnt;
  } vec_t;

  rec_t        sb[$];
  logic [15:0] m_seq;
  logic        m_ovf;
  logic        m_halt;
  int          m_drop;
  int          n_checks = 0;
  int          n_pass = 0;
  vec_t        tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    sb.delete();
    m_seq  = '0;
    m_ovf  = 1'b0;
    m_halt = 1'b0;
    m_drop = 0;
  endtask

  // Called at a falling edge: drive, compare against the model, advance the model, wait one cycle.
  task automatic step(input logic cv, input logic [31:0] pc, input logic [31:0] instr,
                      input logic [4:0] rd, input logic [31:0] wd, input logic rdy);
    bit m_valid;
    bit m_full;
    bit m_pop;
    commit_valid    = cv;
    commit_pc       = pc;
    commit_instr    = instr;
    commit_rd       = rd;
    commit_rd_wdata = wd;
    trace_ready     = rdy;
    #1;
    m_valid = (sb.size() != 0);
    check("trace_valid", 64'(trace_valid), 64'(m_valid));
    check("fifo_count", 64'(fifo_count), 64'(sb.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("drop_count", 64'(drop_count), 64'(m_drop));
    check("halt", 64'(halt), 64'(m_halt));
    if (m_valid) begin
      check("head_seq", 64'(trace_seq), 64'(sb[0].seq));
      check("head_pc", 64'(trace_pc), 64'(sb[0].pc));
      check("head_instr", 64'(trace_instr), 64'(sb[0].instr));
      check("head_rd", 64'(trace_rd), 64'(sb[0].rd));
      check("head_wdata", 64'(trace_rd_wdata), 64'(sb[0].wdata));
    end
    m_full = (sb.size() == DEPTH);
    m_pop  = m_valid && rdy;
    if (m_pop) void'(sb.pop_front());
    if (cv) begin
      if (!m_full || m_pop) sb.push_back('{m_seq, pc, instr, rd, (rd == 5'd0) ? 32'd0 : wd});
      else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      if (instr == 32'h0000006f) m_halt = 1'b1;
      m_seq++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    commit_valid = 1'b0;
    trace_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) step(1'b1, base + 32'(4 * i), 32'h00500293, 5'd5, 32'(i + 100), 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1'b1, 32'h60000000, 32'h00100093, 5'd1, 32'h11, 1'b1, 1'b0, 16'd0, 32'h0,        5'd0, 32'h0,  4'd0};
    tbl[1] = '{1'b1, 32'h60000004, 32'h00200113, 5'd2, 32'h22, 1'b1, 1'b1, 16'd0, 32'h60000000, 5'd1, 32'h11, 4'd1};
    tbl[2] = '{1'b1, 32'h60000008, 32'h00300193, 5'd3, 32'h33, 1'b1, 1'b1, 16'd1, 32'h60000004, 5'd2, 32'h22, 4'd1};
    tbl[3] = '{1'b1, 32'h6000000c, 32'h00400213, 5'd4, 32'h44, 1'b1, 1'b1, 16'd2, 32'h60000008, 5'd3, 32'h33, 4'd1};
    tbl[4] = '{1'b1, 32'h60000010, 32'h00000013, 5'd0, 32'hDEADBEEF, 1'b1, 1'b1, 16'd3, 32'h6000000c, 5'd4, 32'h44, 4'd1};
    tbl[5] = '{1'b0, 32'h0,        32'h0,        5'd0, 32'h0,  1'b1, 1'b1, 16'd4, 32'h60000010, 5'd0, 32'h0,  4'd1};
    tbl[6] = '{1'b0, 32'h0,        32'h0,        5'd0, 32'h0,  1'b1, 1'b0, 16'd0, 32'h0,        5'd0, 32'h0,  4'd0};

    model_reset();
    @(negedge clk);
    do_reset();
    #1;
    check("rst_trace_valid", 64'(trace_valid), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_outputs", 64'({overflow, drop_count, halt}), 64'd0);
    @(negedge clk);

    // In-order delivery with one cycle of latency, including rd==0 masking.
    for (int i = 0; i < 7; i++) begin
      check("tbl_valid", 64'(trace_valid), 64'(tbl[i].e_valid));
      check("tbl_seq", 64'(trace_seq), 64'(tbl[i].e_seq));
      check("tbl_pc", 64'(trace_pc), 64'(tbl[i].e_pc));
      check("tbl_rd", 64'(trace_rd), 64'(tbl[i].e_rd));
      check("tbl_wdata", 64'(trace_rd_wdata), 64'(tbl[i].e_wd));
      check("tbl_count", 64'(fifo_count), 64'(tbl[i].e_cnt));
      step(tbl[i].cv, tbl[i].pc, tbl[i].instr, tbl[i].rd, tbl[i].wd, tbl[i].rdy);
    end

    // Fill, stall, drop, drain, and sequence gap.
    do_reset();
    fill(8, 32'h60000100);
    check("fill_count", 64'(fifo_count), 64'd8);
    check("fill_head_seq", 64'(trace_seq), 64'd0);
    step(1'b1, 32'h60000120, 32'h00600313, 5'd6, 32'h66, 1'b0);
    check("drop_overflow", 64'(overflow), 64'd1);
    check("drop_count_1", 64'(drop_count), 64'd1);
    drain(8);
    step(1'b1, 32'h60000124, 32'h00700393, 5'd7, 32'h77, 1'b1);
    check("gap_seq", 64'(trace_seq), 64'd9);
    drain(1);

    // Full with simultaneous push and pop.
    fill(8, 32'h60000200);
    check("full_count", 64'(fifo_count), 64'd8);
    step(1'b1, 32'h60000220, 32'h00800413, 5'd8, 32'h88, 1'b1);
    check("pushpop_count", 64'(fifo_count), 64'd8);
    check("pushpop_drop", 64'(drop_count), 64'd1);
    drain(7);
    check("pushpop_tail_seq", 64'(trace_seq), 64'd18);
    drain(2);

    // Drop counter saturation.
    fill(8, 32'h60000300);
    for (int i = 0; i < 300; i++) step(1'b1, 32'h60000400, 32'h00900493, 5'd9, 32'(i), 1'b0);
    check("sat_drop_count", 64'(drop_count), 64'd255);
    check("sat_overflow", 64'(overflow), 64'd1);
    drain(9);

    // Halt idiom detection is sticky and the record is still delivered.
    step(1'b1, 32'h60000040, 32'h0000006f, 5'd0, 32'h0, 1'b1);
    check("halt_set", 64'(halt), 64'd1);
    check("halt_instr", 64'(trace_instr), 64'h6f);
    check("halt_pc", 64'(trace_pc), 64'h60000040);
    step(1'b1, 32'h60000044, 32'h00a00513, 5'd10, 32'haa, 1'b1);
    step(1'b1, 32'h60000048, 32'h00b00593, 5'd11, 32'hbb, 1'b1);
    check("halt_sticky", 64'(halt), 64'd1);
    drain(2);

    // Asynchronous reset mid-stream between clock edges.
    fill(3, 32'h60000500);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_trace_valid", 64'(trace_valid), 64'd0);
    check("async_fifo_count", 64'(fifo_count), 64'd0);
    check("async_sticky", 64'({overflow, drop_count, halt}), 64'd0);
    check("async_data", 64'({trace_seq, trace_pc}), 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 32'h60000600, 32'h00c00613, 5'd12, 32'hcc, 1'b0);
    check("post_reset_seq", 64'(trace_seq), 64'd0);
    check("post_reset_valid", 64'(trace_valid), 64'd1);
    drain(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
